// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared FSM encoding and address stride for the program loader
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Byte distance between consecutive instruction words in memory
  localparam int unsigned ADDR_STRIDE = 4;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program into instruction memory while holding the CPU; optional LOADER_CHECKSUM_EN adds a running word sum
module program_loader
  import loader_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         cpu_initialize,
  output logic                         cpu_rst,
  output logic                         done,
  output logic                         error,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0]            checksum,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int WC_W = $clog2(DEPTH + 1);
  localparam logic [WC_W-1:0] DEPTH_WC = WC_W'(DEPTH);

  state_t state;

  // A beat still fits while fewer than DEPTH words have been taken
  logic in_range;
  assign in_range = (word_count < DEPTH_WC);

  // Load sequencer: state, write-port register stage and CPU hold controls all update together
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      word_count     <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= BASE_ADDR;
      mem_wdata      <= '0;
      s_ready        <= 1'b0;
      cpu_initialize <= 1'b1;
      cpu_rst        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        // A reload from RUN re-holds the CPU on the same edge that leaves RUN
        ST_IDLE, ST_RUN: begin
          if (start) begin
            state          <= ST_LOAD;
            word_count     <= '0;
            done           <= 1'b0;
            s_ready        <= 1'b1;
            cpu_initialize <= 1'b1;
            cpu_rst        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum       <= '0;
`endif
          end
        end
        ST_LOAD: begin
          // s_ready is 1 throughout LOAD, so s_valid alone marks an accepted beat
          if (s_valid) begin
            if (in_range) begin
              mem_we     <= 1'b1;
              mem_addr   <= BASE_ADDR + 32'(word_count) * 32'(ADDR_STRIDE);
              mem_wdata  <= s_data;
              word_count <= word_count + WC_W'(1);
`ifdef LOADER_CHECKSUM_EN
              checksum   <= checksum + s_data;
`endif
              if (s_last) begin
                state          <= ST_RUN;
                done           <= 1'b1;
                s_ready        <= 1'b0;
                cpu_initialize <= 1'b0;
                cpu_rst        <= 1'b0;
              end
            end else begin
              // Overflow: the extra beat is dropped and the CPU stays held until reset
              state   <= ST_ERROR;
              error   <= 1'b1;
              s_ready <= 1'b0;
            end
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader against a behavioural model
module tb_program_loader;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_ERR  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        start [2];
  logic        s_valid [2];
  logic        s_last [2];
  logic [31:0] s_data [2];
  logic        s_ready [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        cpu_init [2];
  logic        cpu_rst [2];
  logic        done [2];
  logic        error [2];
  logic [6:0]  wc0;
  logic [2:0]  wc1;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cks_o [2];
`endif

  program_loader #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(32'h0)) u_dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .cpu_initialize(cpu_init[0]), .cpu_rst(cpu_rst[0]),
    .done(done[0]), .error(error[0]),
`ifdef LOADER_CHECKSUM_EN
    .checksum(cks_o[0]),
`endif
    .word_count(wc0)
  );

  program_loader #(.DATA_W(32), .DEPTH(4), .BASE_ADDR(32'h40)) u_dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .cpu_initialize(cpu_init[1]), .cpu_rst(cpu_rst[1]),
    .done(done[1]), .error(error[1]),
`ifdef LOADER_CHECKSUM_EN
    .checksum(cks_o[1]),
`endif
    .word_count(wc1)
  );

  // Reference model state, one entry per instance
  int          dep [2];
  logic [31:0] base [2];
  int          ph [2];
  int          cnt [2];
  bit          m_done [2];
  bit          m_err [2];
  bit          m_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_cks [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Program loader rules applied to what happened at one clock edge
  task automatic model_update(int i, bit r, bit st, bit v, logic [31:0] d, bit l);
    if (!r) begin
      ph[i] = P_IDLE; cnt[i] = 0; m_done[i] = 0; m_err[i] = 0; m_we[i] = 0;
      m_addr[i] = base[i]; m_wdata[i] = 0; m_cks[i] = 0;
      return;
    end
    m_we[i] = 0;
    if ((ph[i] == P_IDLE || ph[i] == P_RUN) && st) begin
      ph[i] = P_LOAD; cnt[i] = 0; m_done[i] = 0; m_cks[i] = 0;
    end else if (ph[i] == P_LOAD && v) begin
      if (cnt[i] < dep[i]) begin
        m_we[i] = 1;
        m_addr[i] = base[i] + 32'(4 * cnt[i]);
        m_wdata[i] = d;
        m_cks[i] = m_cks[i] + d;
        cnt[i] = cnt[i] + 1;
        if (l) begin
          ph[i] = P_RUN; m_done[i] = 1;
        end
      end else begin
        ph[i] = P_ERR; m_err[i] = 1;
      end
    end
  endtask

  task automatic compare(int i);
    logic [31:0] wc;
    wc = (i == 0) ? 32'(wc0) : 32'(wc1);
    check_eq($sformatf("%0d.mem_we", i), 64'(mem_we[i]), 64'(m_we[i]));
    check_eq($sformatf("%0d.mem_addr", i), 64'(mem_addr[i]), 64'(m_addr[i]));
    check_eq($sformatf("%0d.mem_wdata", i), 64'(mem_wdata[i]), 64'(m_wdata[i]));
    check_eq($sformatf("%0d.s_ready", i), 64'(s_ready[i]), 64'(ph[i] == P_LOAD));
    check_eq($sformatf("%0d.cpu_rst", i), 64'(cpu_rst[i]), 64'(ph[i] != P_RUN));
    check_eq($sformatf("%0d.cpu_init", i), 64'(cpu_init[i]), 64'(ph[i] != P_RUN));
    check_eq($sformatf("%0d.done", i), 64'(done[i]), 64'(m_done[i]));
    check_eq($sformatf("%0d.error", i), 64'(error[i]), 64'(m_err[i]));
    check_eq($sformatf("%0d.word_count", i), 64'(wc), 64'(cnt[i]));
`ifdef LOADER_CHECKSUM_EN
    check_eq($sformatf("%0d.checksum", i), 64'(cks_o[i]), 64'(m_cks[i]));
`endif
  endtask

  // One clock on instance i; the other instance sees idle inputs
  task automatic step(int i, bit r, bit st, bit v, logic [31:0] d, bit l);
    rst[i] = r; start[i] = st; s_valid[i] = v; s_data[i] = d; s_last[i] = l;
    @(posedge clk);
    model_update(i, r, st, v, d, l);
    #1;
    compare(i);
    rst[i] = 1'b1; start[i] = 1'b0; s_valid[i] = 1'b0; s_last[i] = 1'b0;
  endtask

  // Start then stream words with random s_valid gaps; last word carries s_last
  task automatic load_words(int i, logic [31:0] words [$], bit gaps);
    step(i, 1, 1, 0, 32'h0, 0);
    for (int k = 0; k < words.size(); k++) begin
      bit v;
      v = 0;
      while (!v) begin
        v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
        step(i, 1, 0, v, v ? words[k] : $urandom, (k == words.size() - 1));
      end
    end
  endtask

  initial begin
    logic [31:0] prog [$];
    dep[0] = 64; dep[1] = 4;
    base[0] = 32'h0; base[1] = 32'h40;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 0; start[i] = 0; s_valid[i] = 0; s_last[i] = 0; s_data[i] = 0;
      ph[i] = P_IDLE; cnt[i] = 0;
    end
    // Reset both instances
    repeat (2) begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_update(i, 0, 0, 0, 0, 0);
      #1;
      for (int i = 0; i < 2; i++) compare(i);
    end
    rst[0] = 1; rst[1] = 1;
    step(0, 1, 0, 0, 0, 0);

    // Reference three-word program
    prog = '{32'h00021020, 32'h0084402A, 32'h00C53825};
    load_words(0, prog, 0);
    check_eq("a.count3", 64'(wc0), 64'd3);
    check_eq("a.last_addr", 64'(mem_addr[0]), 64'h8);

    // Reloads with random lengths and s_valid gaps, including single-word programs
    for (int n = 0; n < 12; n++) begin
      int len;
      len = (n < 2) ? 1 : $urandom_range(1, 12);
      prog = {};
      for (int k = 0; k < len; k++) prog.push_back($urandom);
      load_words(0, prog, 1);
      repeat ($urandom_range(0, 3)) step(0, 1, 0, 0, 0, 0);
    end

    // Reset in the same cycle as a beat mid-load
    prog = '{$urandom, $urandom, $urandom, $urandom};
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, $urandom, 0);
    step(0, 1, 0, 1, $urandom, 0);
    step(0, 0, 0, 1, $urandom, 0);
    step(0, 1, 0, 0, 0, 0);
    check_eq("a.rst_mid_we", 64'(mem_we[0]), 64'd0);

    // DEPTH=4: five beats without last overflow into ERROR; start is ignored there
    step(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 1, $urandom, 0);
    check_eq("b.overflow_err", 64'(error[1]), 64'd1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, $urandom, 1);
    check_eq("b.err_cpu_rst", 64'(cpu_rst[1]), 64'd1);
    step(1, 0, 0, 0, 0, 0);

    // DEPTH=4: fourth beat carries last, exactly filling the program
    prog = '{$urandom, $urandom, $urandom, $urandom};
    load_words(1, prog, 1);
    check_eq("b.full_count", 64'(wc1), 64'd4);
    check_eq("b.full_err", 64'(error[1]), 64'd0);

    // Reload from RUN with a two-word program at base 0x40
    prog = '{$urandom, $urandom};
    load_words(1, prog, 0);
    check_eq("b.reload_addr", 64'(mem_addr[1]), 64'h44);
`ifdef LOADER_CHECKSUM_EN
    check_eq("b.reload_cks", 64'(cks_o[1]), 64'(prog[0] + prog[1]));
`endif

    // Free-running random traffic on both instances
    for (int n = 0; n < 800; n++) begin
      int i;
      i = $urandom_range(0, 1);
      step(i, ($urandom_range(0, 60) != 0), ($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the maximum number of words per program.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning the byte address of the first word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: a single-cycle request to begin a program load.
REQ-007 The block SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, DATA_W) and s_last (input, 1): the program word stream.
REQ-008 The block SHALL have ports mem_we (output, 1), mem_addr (output, 32, byte address) and mem_wdata (output, DATA_W): the instruction-memory write port.
REQ-009 The block SHALL have ports cpu_initialize (output, 1) and cpu_rst (output, 1, active-high): the CPU hold controls.
REQ-010 The block SHALL have ports done (output, 1), error (output, 1) and word_count (output, clog2(DEPTH+1) bits).

Function
REQ-011 The block SHALL implement the FSM states IDLE, LOAD, RUN and ERROR.
REQ-012 IDLE SHALL go to LOAD on start=1; start SHALL be ignored in LOAD and ERROR.
REQ-013 RUN SHALL go to LOAD on start=1 (reload): word_count cleared, done cleared, and the CPU re-held in the same cycle.
REQ-014 s_ready SHALL be 1 only in LOAD; a beat is accepted when s_valid and s_ready are both 1.
REQ-015 An accepted beat with word_count<DEPTH SHALL drive, on the next cycle only, mem_we=1, mem_addr=BASE_ADDR+4*word_count and mem_wdata=s_data; word_count SHALL increment on acceptance (write latency 1 cycle).
REQ-016 mem_we SHALL be 0 in every cycle that does not follow an accepted, in-range beat.
REQ-017 An accepted beat with s_last=1 and in range SHALL move the FSM to RUN; done, cpu_initialize=0 and cpu_rst=0 SHALL become visible in the same cycle as that beat's mem_we.
REQ-018 A beat accepted while word_count==DEPTH SHALL not be written and SHALL move the FSM to ERROR, setting error=1 (overflow).
REQ-019 In ERROR: s_ready=0, mem_we=0, cpu_initialize=1 and cpu_rst=1; only reset exits ERROR.
REQ-020 In IDLE, LOAD and ERROR, cpu_initialize=1 and cpu_rst=1; in RUN, both SHALL be 0.
REQ-021 Boundaries: a single-word program (first beat has s_last=1) SHALL be valid; beat DEPTH with s_last=1 SHALL be valid; s_valid gaps in LOAD SHALL only stall.

Reset
REQ-022 While rst=0 at a clock edge, the block SHALL enter IDLE with word_count=0, done=0, error=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, s_ready=0, cpu_initialize=1 and cpu_rst=1.
REQ-023 Reset during LOAD SHALL abandon the load, with no pending write issued after reset.

Configuration
REQ-024 With LOADER_CHECKSUM_EN defined, the block SHALL add an output checksum (DATA_W bits): the modulo-2^DATA_W sum of all words written in the current load, cleared on reset and on entry to LOAD, and stable in RUN.
REQ-025 Without LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 The FSM state encoding and the address stride constant (4) SHALL live in the shared package loader_pkg.
REQ-027 The design SHALL be a single module with no sub-modules; the write-port register stage is inline.

Verification
REQ-028 Reset then start, then beats 0x00021020, 0x0084402A, 0x00C53825 (last): three writes at addresses 0, 4, 8, each one cycle after acceptance; done=1, cpu_rst=0, word_count=3.
REQ-029 s_valid toggling 1/0 during a load: writes occur only for accepted beats, and addresses stay contiguous.
REQ-030 DEPTH=4, five beats without last: four writes (0..12), the fifth beat is not written, error=1, and cpu_rst stays 1 until reset.
REQ-031 DEPTH=4, fourth beat has s_last: RUN, error=0, word_count=4.
REQ-032 From RUN, start with a 2-word program at BASE_ADDR=0x40: cpu_rst rises immediately, writes go to 0x40 and 0x44, then RUN; with LOADER_CHECKSUM_EN, checksum equals the sum of those 2 words only.
REQ-033 rst=0 asserted in the same cycle as a beat mid-LOAD: the next cycle shows mem_we=0, IDLE, and word_count=0.
